// File: rtl/reg_scoreboard_ctrl.sv
// Issue-side hazard controller: per-register pending-write counters, RAW and
// saturation stalls, and flush sequencing that drains outstanding writebacks.
module reg_scoreboard_ctrl #(
    parameter int NREG     = 32,
    parameter int CNT_W    = 2,
    parameter int WB_PORTS = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   issue_valid,
    output logic                                   issue_ready,
    input  logic [$clog2(NREG)-1:0]                issue_rs1,
    input  logic [$clog2(NREG)-1:0]                issue_rs2,
    input  logic                                   issue_rs1_en,
    input  logic                                   issue_rs2_en,
    input  logic [$clog2(NREG)-1:0]                issue_rd,
    input  logic                                   issue_wen,
    input  logic [WB_PORTS-1:0]                    wb_valid,
    input  logic [WB_PORTS-1:0][$clog2(NREG)-1:0]  wb_rd,
    input  logic                                   flush,
    output logic                                   idle,
    output logic                                   draining,
    output logic                                   err
);
    localparam int IDX_W = $clog2(NREG);
    localparam int DEC_W = $clog2(WB_PORTS + 1);
    localparam int SUM_W = CNT_W + DEC_W + 1;
    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [SUM_W-1:0] ZERO_SUM = {SUM_W{1'b0}};
    localparam logic [SUM_W-1:0] ONE_SUM  = {{(SUM_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r      [NREG];
    logic [CNT_W-1:0] cnt_next_s [NREG];
    logic             raw1_s;
    logic             raw2_s;
    logic             sat_s;
    logic             fire_s;
    logic             underflow_s;
    logic             all_zero_next_s;
    logic             idle_r;
    logic             draining_r;
    logic             err_r;

    // Hazard detection against current counter values (no release bypass).
    always_comb begin
        raw1_s      = issue_rs1_en && (issue_rs1 != ZERO_IDX) && (cnt_r[issue_rs1] != ZERO_CNT);
        raw2_s      = issue_rs2_en && (issue_rs2 != ZERO_IDX) && (cnt_r[issue_rs2] != ZERO_CNT);
        sat_s       = issue_wen && (issue_rd != ZERO_IDX) && (cnt_r[issue_rd] == CNT_MAX);
        issue_ready = (state_r == ST_RUN) && !flush && !raw1_s && !raw2_s && !sat_s;
        fire_s      = issue_valid && issue_ready;
    end

    // Next counter values: issue increments, releases decrement, underflow is dropped.
    always_comb begin
        logic [SUM_W-1:0] inc_v;
        logic [SUM_W-1:0] dec_v;
        logic [SUM_W-1:0] total_v;
        underflow_s     = 1'b0;
        all_zero_next_s = 1'b1;
        cnt_next_s[0]   = ZERO_CNT;
        for (int r = 1; r < NREG; r++) begin
            if (fire_s && issue_wen && (issue_rd == IDX_W'(r))) begin
                inc_v = ONE_SUM;
            end else begin
                inc_v = ZERO_SUM;
            end
            dec_v = ZERO_SUM;
            for (int j = 0; j < WB_PORTS; j++) begin
                if (wb_valid[j] && (wb_rd[j] == IDX_W'(r))) begin
                    dec_v = dec_v + ONE_SUM;
                end else begin
                    dec_v = dec_v;
                end
            end
            total_v = SUM_W'(cnt_r[r]) + inc_v;
            if (dec_v > total_v) begin
                cnt_next_s[r] = ZERO_CNT;
                underflow_s   = 1'b1;
            end else begin
                cnt_next_s[r] = CNT_W'(total_v - dec_v);
            end
            if (cnt_next_s[r] != ZERO_CNT) begin
                all_zero_next_s = 1'b0;
            end else begin
                all_zero_next_s = all_zero_next_s;
            end
        end
    end

    // Counter storage, sticky error and RUN/DRAIN state with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= ZERO_CNT;
            end
            state_r    <= ST_RUN;
            idle_r     <= 1'b1;
            draining_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= cnt_next_s[r];
            end
            err_r <= err_r | underflow_s;
            case (state_r)
                ST_RUN: begin
                    if (flush && !all_zero_next_s) begin
                        state_r    <= ST_DRAIN;
                        draining_r <= 1'b1;
                        idle_r     <= 1'b0;
                    end else begin
                        state_r    <= ST_RUN;
                        draining_r <= 1'b0;
                        idle_r     <= all_zero_next_s;
                    end
                end
                ST_DRAIN: begin
                    if (all_zero_next_s) begin
                        state_r    <= ST_RUN;
                        draining_r <= 1'b0;
                        idle_r     <= 1'b1;
                    end else begin
                        state_r    <= ST_DRAIN;
                        draining_r <= 1'b1;
                        idle_r     <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_RUN;
                    draining_r <= 1'b0;
                    idle_r     <= 1'b0;
                end
            endcase
        end
    end

    assign idle     = idle_r;
    assign draining = draining_r;
    assign err      = err_r;

endmodule

// File: tb/tb_reg_scoreboard_ctrl.sv
// Scoreboard bench for reg_scoreboard_ctrl: the driver queues the expected
// {issue_ready, idle, draining, err} per cycle; a monitor pops and compares.
module tb_reg_scoreboard_ctrl;
    logic             clk = 1'b0;
    logic             reset;
    logic             issue_valid;
    logic             issue_ready;
    logic [4:0]       issue_rs1;
    logic [4:0]       issue_rs2;
    logic             issue_rs1_en;
    logic             issue_rs2_en;
    logic [4:0]       issue_rd;
    logic             issue_wen;
    logic [1:0]       wb_valid;
    logic [1:0][4:0]  wb_rd;
    logic             flush;
    logic             idle;
    logic             draining;
    logic             err;

    typedef struct {
        string      name;
        logic [3:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    reg_scoreboard_ctrl #(.NREG(32), .CNT_W(2), .WB_PORTS(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_rs1_en(issue_rs1_en),
        .issue_rs2_en(issue_rs2_en),
        .issue_rd    (issue_rd),
        .issue_wen   (issue_wen),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .flush       (flush),
        .idle        (idle),
        .draining    (draining),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Monitor: one expected record per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [3:0] act;
            e   = exp_q.pop_front();
            act = {issue_ready, idle, draining, err};
            n_vec++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: {ready,idle,draining,err} got %b expected %b", e.name, act, e.exp);
            end
        end
    end

    // x = expected {issue_ready, idle, draining, err} during this cycle
    task automatic step(input string nm, input logic rst, input logic vld,
                        input logic [4:0] rs1, input logic e1,
                        input logic [4:0] rs2, input logic e2,
                        input logic [4:0] rd, input logic wen,
                        input logic [1:0] wbv, input logic [4:0] w0, input logic [4:0] w1,
                        input logic fl, input logic [3:0] x);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst;
        issue_valid  = vld;
        issue_rs1    = rs1;
        issue_rs1_en = e1;
        issue_rs2    = rs2;
        issue_rs2_en = e2;
        issue_rd     = rd;
        issue_wen    = wen;
        wb_valid     = wbv;
        wb_rd        = {w1, w0};
        flush        = fl;
        e.name = nm;
        e.exp  = x;
        exp_q.push_back(e);
    endtask

    task automatic nop(input string nm, input logic [3:0] x);
        step(nm, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, x);
    endtask

    task automatic iss(input string nm, input logic [4:0] rd, input logic [3:0] x);
        step(nm, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, x);
    endtask

    initial begin
        reset = 1'b1; issue_valid = 1'b0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
        issue_rs1_en = 1'b0; issue_rs2_en = 1'b0; issue_rd = 5'd0; issue_wen = 1'b0;
        wb_valid = 2'b00; wb_rd = 10'd0; flush = 1'b0;
        repeat (2) @(posedge clk);

        nop("reset_state", 4'b1100);
        // RAW: add x5 then addi x6,x5
        iss("wr_x5", 5'd5, 4'b1100);
        step("raw_x5", 1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, 4'b0000);
        step("raw_wb_same_cyc", 1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 2'b01, 5'd5, 5'd0, 1'b0, 4'b0000);
        step("raw_cleared", 1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, 4'b1100);
        step("wb_x6_port1", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b10, 5'd0, 5'd6, 1'b0, 4'b1000);
        nop("idle_after_raw", 4'b1100);
        // Saturation of x7
        iss("sat_w1", 5'd7, 4'b1100);
        iss("sat_w2", 5'd7, 4'b1000);
        iss("sat_w3", 5'd7, 4'b1000);
        iss("sat_w4_stall", 5'd7, 4'b0000);
        iss("other_rd_x8", 5'd8, 4'b1000);
        step("wb_x7_x7", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b11, 5'd7, 5'd7, 1'b0, 4'b1000);
        step("wb_x7_x8", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b11, 5'd7, 5'd8, 1'b0, 4'b1000);
        nop("idle_after_sat", 4'b1100);
        // Same-cycle issue/release and dual-port release
        iss("wr_x9", 5'd9, 4'b1100);
        step("fire_and_wb_x9", 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'b01, 5'd9, 5'd0, 1'b0, 4'b1000);
        iss("wr_x10_a", 5'd10, 4'b1000);
        iss("wr_x10_b", 5'd10, 4'b1000);
        step("x9_still_1", 1'b0, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b11, 5'd10, 5'd10, 1'b0, 4'b0000);
        step("x10_now_0", 1'b0, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 4'b1000);
        step("wb_x9_last", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd9, 5'd0, 1'b0, 4'b1000);
        nop("idle_after_same", 4'b1100);
        // Underflow sets sticky err; x0 is untracked
        step("wb_x11_underflow", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd11, 5'd0, 1'b0, 4'b1100);
        nop("err_sticky", 4'b1101);
        step("x0_wb_issue", 1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 2'b10, 5'd0, 5'd0, 1'b0, 4'b1101);
        step("x0_issue_b", 1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, 4'b1101);
        iss("x0_issue_c", 5'd0, 4'b1101);
        iss("x0_issue_d", 5'd0, 4'b1101);
        // Flush with x3 and x4 pending
        iss("wr_x3", 5'd3, 4'b1101);
        iss("wr_x4", 5'd4, 4'b1001);
        step("flush_pending", 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 2'b00, 5'd0, 5'd0, 1'b1, 4'b0001);
        iss("drain_blocked", 5'd1, 4'b0011);
        step("drain_wb_x3", 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 2'b01, 5'd3, 5'd0, 1'b0, 4'b0011);
        step("drain_wb_x4", 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 2'b10, 5'd0, 5'd4, 1'b0, 4'b0011);
        iss("resume_issue", 5'd1, 4'b1101);
        step("wb_x1", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd1, 5'd0, 1'b0, 4'b1001);
        step("flush_empty", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 4'b0101);
        nop("run_after_flush", 4'b1101);
        // Reset in the middle of DRAIN
        iss("wr_x12_a", 5'd12, 4'b1101);
        iss("wr_x12_b", 5'd12, 4'b1001);
        step("flush_x12", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 4'b0001);
        step("reset_in_drain", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 4'b0011);
        nop("post_reset", 4'b1100);
        step("x12_cleared", 1'b0, 1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 4'b1100);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain_queue: %0d expected records left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
